mem_stage_split: RTL and testbench
==================================

Name: mem_stage_split

Overview:
Next-generation MEM stage. Replaces the single-cycle, ideal data-memory access with a req/gnt/rvalid handshake to an external data memory, and adds valid/ready flow control toward EX/MEM and MEM/WB.
Misaligned loads and stores are split into two aligned word beats, or raise an exception, depending on a parameter. Store byte strobes, load extraction and sign extension are integrated. ALU and FP results are registered and passed through alongside the load result.

Parameters:
ADDR_W, 32, byte-address width (data width fixed at 32).
SPLIT_MISALIGNED, 1, 1 = split crossing accesses into two beats; 0 = flag misalign_exc and perform no memory access.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  EX/MEM holds a valid op
in_ready  out  1  stage accepts op (deassert = pipeline stall)
mem_read  in  1  load op
mem_write  in  1  store op (wins if both read and write are high)
mem_address  in  ADDR_W  byte address
store_data  in  32  store source data
load_width  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
store_width  in  3  000 SB, 001 SH, 010 SW
alu_result  in  32  pass-through
fp_alu_result  in  32  pass-through
out_valid  out  1  MEM/WB result valid
out_ready  in  1  MEM/WB accepts
mem_load_data  out  32  extended load result
mem_alu_result  out  32  registered alu_result
mem_fp_result  out  32  registered fp_alu_result
misalign_exc  out  1  misaligned access, no memory effect (SPLIT_MISALIGNED=0 only)
access_fault  out  1  dmem_err returned on any beat
dmem_req  out  1  request valid
dmem_we  out  1  write request
dmem_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
dmem_wdata  out  32  lane-positioned write data
dmem_wstrb  out  4  byte enables
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  response/ack for reads and writes
dmem_rdata  in  32  read data
dmem_err  in  1  bus error, qualified by dmem_rvalid

Behaviour:
- States: IDLE, REQ0, RSP0, REQ1, RSP1.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept = in_valid && in_ready; the op is latched into internal registers.
- Non-memory op (neither read nor write): out_valid is asserted the cycle after accept. No dmem activity.
- Offset off = addr[1:0]; size = 1/2/4 bytes.
- Crossing = off + size > 4. With SPLIT_MISALIGNED=0, crossing also requires natural misalignment.
  - SPLIT_MISALIGNED=0: a crossing op completes like a non-memory op, with misalign_exc=1 and mem_load_data=0.
  - SPLIT_MISALIGNED=1: a crossing op takes two beats.
- Beat addresses: beat0 = {addr[ADDR_W-1:2],00}. Beat1 = beat0+4, wrapping modulo 2^ADDR_W.
- Full mask = ((1<<size)-1) << off, an 8-bit value.
  - Beat0 strobe = mask[3:0]; beat1 strobe = mask[7:4].
  - Beat0 wdata = store_data << 8*off; beat1 wdata = store_data >> 8*(4-off).
- REQ0/REQ1: dmem_req=1 with addr, we, wdata and wstrb stable until dmem_gnt; move to RSPx on gnt.
- RSP0/RSP1: dmem_req=0; wait for dmem_rvalid. Beat0 rdata is captured in RSP0.
  - If beat1 is needed and no error: go to REQ1.
  - Otherwise: go to IDLE, with out_valid registered high the same edge.
- Load result = ({rdata1,rdata0} >> 8*off), truncated to size, then sign- or zero-extended per load_width. rdata1 = 0 for single-beat ops.
- dmem_err on beat0 skips beat1 and sets access_fault=1 on the output. A store's beat0 write is not undone.
- Outputs hold while out_valid && !out_ready. out_valid drops on the out_ready edge unless a new non-memory op completes.
- Minimum latency for an aligned access with gnt in the REQ cycle and rvalid in the next cycle: out_valid 3 cycles after the accept cycle. A split access adds 2 cycles.
- dmem_rvalid in IDLE/REQx is ignored.
- Reset (any state, including mid-transaction):
  - state=IDLE.
  - dmem_req=0, dmem_we=0, dmem_wstrb=0, dmem_addr=0, dmem_wdata=0.
  - out_valid=0, misalign_exc=0, access_fault=0, all data outputs 0.
  - A late rvalid after reset is ignored.
- Unused width encodings (011, 11x) are treated as word accesses.

Decomposition:
- Package mem_stage_pkg holds:
  - width encodings (LS_B, LS_H, LS_W, LS_BU, LS_HU);
  - state enum;
  - function size_of(width).
- One combinational sub-module, mem_align_unit: inputs offset, width, store data and the two rdata words; outputs 8-bit mask, both beat wdata values and the extended load result.
- The FSM and registers live in mem_stage_split.

Test Plan:
1. LW at 0x100, rdata 0xDEADBEEF, gnt immediate, rvalid next cycle -> one beat at 0x100, wstrb 0000, mem_load_data 0xDEADBEEF, out_valid 3 cycles after accept.
2. SW at 0x102, data 0xAABBCCDD -> beat0: 0x100, wstrb 1100, wdata 0xCCDD0000; beat1: 0x104, wstrb 0011, wdata 0x0000AABB; no out_valid before the beat1 rvalid.
3. LH at 0x203, words 0x11223344/0x55667788 -> 0xFFFF8811. LHU at the same address -> 0x00008811. LB at 0x001 with word 0x00008000 -> 0xFFFFFF80.
4. SPLIT_MISALIGNED=0, LW at 0x101 -> dmem_req never asserted; misalign_exc=1 one cycle after accept.
5. gnt held low 5 cycles, then out_ready low 3 cycles -> request fields stable throughout, outputs held, in_ready=0 until the result is consumed.
6. rst asserted in RSP0, then rvalid arrives -> IDLE, all outputs 0, rvalid ignored; the next op completes normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared encodings, state type and helpers for the split-capable MEM stage.
package mem_stage_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ0 = 3'd1,
        RSP0 = 3'd2,
        REQ1 = 3'd3,
        RSP1 = 3'd4
    } state_t;

    // Access size in bytes; unused encodings behave as word accesses.
    function automatic logic [2:0] size_of(input logic [2:0] width);
        case (width)
            LS_B, LS_BU: size_of = 3'd1;
            LS_H, LS_HU: size_of = 3'd2;
            default:     size_of = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_align_unit.sv
// Combinational lane alignment: byte mask, per-beat store data and
// load extraction with sign/zero extension over a two-word window.
module mem_align_unit
    import mem_stage_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  width,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata0,
    input  logic [31:0] rdata1,
    output logic [7:0]  mask,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] load_data
);

    logic [4:0]  shamt;
    logic [7:0]  base_mask;
    logic [63:0] wide_wdata;
    logic [31:0] shifted;

    always_comb begin
        shamt = {offset, 3'b000};
        case (size_of(width))
            3'd1:    base_mask = 8'h01;
            3'd2:    base_mask = 8'h03;
            default: base_mask = 8'h0F;
        endcase
        mask = base_mask << offset;

        // Upper half of the shifted store word is what spills into beat 1.
        wide_wdata = {32'h0, store_data} << shamt;
        wdata0     = wide_wdata[31:0];
        wdata1     = wide_wdata[63:32];

        shifted = 32'({rdata1, rdata0} >> shamt);
        case (width)
            LS_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            LS_BU:   load_data = {24'h0, shifted[7:0]};
            LS_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            LS_HU:   load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_split.sv
// MEM stage with req/gnt/rvalid data-memory handshake, valid/ready flow
// control and optional two-beat splitting of word-crossing accesses.
module mem_stage_split
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W           = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [31:0]       store_data,
    input  logic [2:0]        load_width,
    input  logic [2:0]        store_width,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       fp_alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       mem_load_data,
    output logic [31:0]       mem_alu_result,
    output logic [31:0]       mem_fp_result,
    output logic              misalign_exc,
    output logic              access_fault,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic [3:0]        dmem_wstrb,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_err
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic              we_reg;
    logic [2:0]        width_reg;
    logic [31:0]       store_data_reg;
    logic              two_beat_reg;
    logic [31:0]       rdata0_reg;
    logic              out_valid_reg, misalign_reg, fault_reg;
    logic [31:0]       load_data_reg, alu_reg, fp_reg;

    logic              accept, is_mem, crossing, exc, done;
    logic [2:0]        in_width;
    logic [ADDR_W-1:0] beat0_addr, beat1_addr;
    logic [31:0]       rdata0_sel, rdata1_sel;
    logic [7:0]        mask;
    logic [31:0]       wdata0, wdata1, ext_load;

    assign in_ready = (state_reg == IDLE) && (!out_valid_reg || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mem   = mem_read || mem_write;
    assign in_width = mem_write ? store_width : load_width;
    // For power-of-two sizes, crossing a word always implies natural misalignment.
    assign crossing = ({2'b00, mem_address[1:0]} + {1'b0, size_of(in_width)}) > 4'd4;
    assign exc      = crossing && !SPLIT_MISALIGNED;

    assign beat0_addr = {addr_reg[ADDR_W-1:2], 2'b00};
    assign beat1_addr = beat0_addr + ADDR_W'(4);
    assign rdata0_sel = (state_reg == RSP0) ? dmem_rdata : rdata0_reg;
    assign rdata1_sel = (state_reg == RSP1) ? dmem_rdata : 32'h0;

    mem_align_unit u_align (
        .offset     (addr_reg[1:0]),
        .width      (width_reg),
        .store_data (store_data_reg),
        .rdata0     (rdata0_sel),
        .rdata1     (rdata1_sel),
        .mask       (mask),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .load_data  (ext_load)
    );

    always_comb begin
        dmem_req   = (state_reg == REQ0) || (state_reg == REQ1);
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = 32'h0;
        dmem_wstrb = 4'h0;
        if (dmem_req) begin
            dmem_we   = we_reg;
            dmem_addr = (state_reg == REQ1) ? beat1_addr : beat0_addr;
            if (we_reg) begin
                dmem_wdata = (state_reg == REQ1) ? wdata1 : wdata0;
                dmem_wstrb = (state_reg == REQ1) ? mask[7:4] : mask[3:0];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        done       = 1'b0;
        case (state_reg)
            IDLE: if (accept && is_mem && !exc) state_next = REQ0;
            REQ0: if (dmem_gnt) state_next = RSP0;
            RSP0: if (dmem_rvalid) begin
                if (two_beat_reg && !dmem_err) begin
                    state_next = REQ1;
                end else begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            REQ1: if (dmem_gnt) state_next = RSP1;
            RSP1: if (dmem_rvalid) begin
                state_next = IDLE;
                done       = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            addr_reg       <= '0;
            we_reg         <= 1'b0;
            width_reg      <= 3'b000;
            store_data_reg <= 32'h0;
            two_beat_reg   <= 1'b0;
            rdata0_reg     <= 32'h0;
            out_valid_reg  <= 1'b0;
            misalign_reg   <= 1'b0;
            fault_reg      <= 1'b0;
            load_data_reg  <= 32'h0;
            alu_reg        <= 32'h0;
            fp_reg         <= 32'h0;
        end else begin
            state_reg <= state_next;
            if (state_reg == RSP0 && dmem_rvalid) rdata0_reg <= dmem_rdata;
            if (accept) begin
                addr_reg       <= mem_address;
                we_reg         <= mem_write;
                width_reg      <= in_width;
                store_data_reg <= store_data;
                two_beat_reg   <= crossing;
                alu_reg        <= alu_result;
                fp_reg         <= fp_alu_result;
                load_data_reg  <= 32'h0;
                fault_reg      <= 1'b0;
                misalign_reg   <= is_mem && exc;
                out_valid_reg  <= !is_mem || exc;
            end else if (done) begin
                out_valid_reg <= 1'b1;
                fault_reg     <= dmem_err;
                load_data_reg <= (we_reg || dmem_err) ? 32'h0 : ext_load;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid      = out_valid_reg;
    assign mem_load_data  = load_data_reg;
    assign mem_alu_result = alu_reg;
    assign mem_fp_result  = fp_reg;
    assign misalign_exc   = misalign_reg;
    assign access_fault   = fault_reg;

endmodule

// File: tb/tb_mem_stage_split.sv
// Directed bench for mem_stage_split: aligned, split, extension, exception,
// stall/hold and mid-transaction reset cases with hand-computed expectations.
`timescale 1ns/1ps
module tb_mem_stage_split;
    import mem_stage_pkg::*;

    logic        clk, rst;
    logic        in_valid, in_ready, mem_read, mem_write;
    logic [31:0] mem_address, store_data, alu_result, fp_alu_result;
    logic [2:0]  load_width, store_width;
    logic        out_valid, out_ready, misalign_exc, access_fault;
    logic [31:0] mem_load_data, mem_alu_result, mem_fp_result;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid, dmem_err;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;

    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b;
    logic        misalign_b, fault_b, req_b, we_b, gnt_b, rvalid_b, err_b;
    logic [31:0] load_b, alu_b, fp_b, addr_b, wdata_b, rdata_b;
    logic [3:0]  wstrb_b;

    int checks = 0;
    int failures = 0;

    mem_stage_split #(.ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .store_data(store_data), .load_width(load_width), .store_width(store_width),
        .alu_result(alu_result), .fp_alu_result(fp_alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .mem_load_data(mem_load_data),
        .mem_alu_result(mem_alu_result), .mem_fp_result(mem_fp_result),
        .misalign_exc(misalign_exc), .access_fault(access_fault),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .dmem_err(dmem_err)
    );

    mem_stage_split #(.ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) dut_nosplit (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .store_data(store_data), .load_width(load_width), .store_width(store_width),
        .alu_result(alu_result), .fp_alu_result(fp_alu_result),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .mem_load_data(load_b),
        .mem_alu_result(alu_b), .mem_fp_result(fp_b),
        .misalign_exc(misalign_b), .access_fault(fault_b),
        .dmem_req(req_b), .dmem_we(we_b), .dmem_addr(addr_b),
        .dmem_wdata(wdata_b), .dmem_wstrb(wstrb_b), .dmem_gnt(gnt_b),
        .dmem_rvalid(rvalid_b), .dmem_rdata(rdata_b), .dmem_err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Present one op at a negedge and let it be accepted on the next edge.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [2:0] lw, input logic [2:0] sw,
                         input logic [31:0] alu, input logic [31:0] fp);
        mem_read = rd; mem_write = wr; mem_address = addr; store_data = sdata;
        load_width = lw; store_width = sw; alu_result = alu; fp_alu_result = fp;
        in_valid = 1'b1;
        #1;
        chk("in_ready_at_issue", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Serve one memory beat: check request fields for every REQ cycle, grant
    // after 'delay' cycles, then respond one cycle later.
    task automatic beat(input string tag, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wdata, input logic we, input int delay,
                        input logic [31:0] rdata, input logic err);
        for (int i = 0; i <= delay; i++) begin
            chk({tag, ".req"},   32'(dmem_req), 32'd1);
            chk({tag, ".addr"},  dmem_addr, addr);
            chk({tag, ".we"},    32'(dmem_we), 32'(we));
            chk({tag, ".wstrb"}, 32'(dmem_wstrb), 32'(strb));
            chk({tag, ".wdata"}, dmem_wdata, wdata);
            if (i == delay) dmem_gnt = 1'b1;
            @(negedge clk);
        end
        dmem_gnt = 1'b0;
        chk({tag, ".req_rsp"}, 32'(dmem_req), 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = rdata; dmem_err = err;
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0; dmem_err = 1'b0;
    endtask

    task automatic result(input string tag, input logic [31:0] ld, input logic [31:0] alu,
                          input logic [31:0] fp, input logic mis, input logic flt);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".load"},      mem_load_data, ld);
        chk({tag, ".alu"},       mem_alu_result, alu);
        chk({tag, ".fp"},        mem_fp_result, fp);
        chk({tag, ".misalign"},  32'(misalign_exc), 32'(mis));
        chk({tag, ".fault"},     32'(access_fault), 32'(flt));
        $display("TXN %s load=0x%08h alu=0x%08h fp=0x%08h mis=%0b fault=%0b",
                 tag, mem_load_data, mem_alu_result, mem_fp_result, misalign_exc, access_fault);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        mem_address = 32'h0; store_data = 32'h0; load_width = LS_W; store_width = LS_W;
        alu_result = 32'h0; fp_alu_result = 32'h0; out_ready = 1'b1;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0; dmem_err = 1'b0;
        in_valid_b = 1'b0; out_ready_b = 1'b1; gnt_b = 1'b0; rvalid_b = 1'b0;
        rdata_b = 32'h0; err_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.req", 32'(dmem_req), 32'd0);
        chk("rst.addr", dmem_addr, 32'h0);
        chk("rst.alu", mem_alu_result, 32'h0);
        chk("rst.misalign", 32'(misalign_exc), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Aligned LW, minimum latency: result visible 3 cycles after accept.
        issue(1'b1, 1'b0, 32'h100, 32'h0, LS_W, LS_W, 32'hA1, 32'hF1);
        chk("lw.no_early", 32'(out_valid), 32'd0);
        beat("lw", 32'h100, 4'b0000, 32'h0, 1'b0, 0, 32'hDEADBEEF, 1'b0);
        result("lw", 32'hDEADBEEF, 32'hA1, 32'hF1, 1'b0, 1'b0);

        // Split SW across 0x100/0x104.
        issue(1'b0, 1'b1, 32'h102, 32'hAABBCCDD, LS_W, LS_W, 32'hA2, 32'hF2);
        beat("sw.b0", 32'h100, 4'b1100, 32'hCCDD0000, 1'b1, 0, 32'h0, 1'b0);
        chk("sw.no_early", 32'(out_valid), 32'd0);
        beat("sw.b1", 32'h104, 4'b0011, 32'h0000AABB, 1'b1, 0, 32'h0, 1'b0);
        result("sw", 32'h0, 32'hA2, 32'hF2, 1'b0, 1'b0);

        // Split LH / LHU at 0x203.
        issue(1'b1, 1'b0, 32'h203, 32'h0, LS_H, LS_W, 32'hA3, 32'hF3);
        beat("lh.b0", 32'h200, 4'b0000, 32'h0, 1'b0, 0, 32'h11223344, 1'b0);
        chk("lh.no_early", 32'(out_valid), 32'd0);
        beat("lh.b1", 32'h204, 4'b0000, 32'h0, 1'b0, 0, 32'h55667788, 1'b0);
        result("lh", 32'hFFFF8811, 32'hA3, 32'hF3, 1'b0, 1'b0);
        issue(1'b1, 1'b0, 32'h203, 32'h0, LS_HU, LS_W, 32'hA4, 32'hF4);
        beat("lhu.b0", 32'h200, 4'b0000, 32'h0, 1'b0, 0, 32'h11223344, 1'b0);
        beat("lhu.b1", 32'h204, 4'b0000, 32'h0, 1'b0, 0, 32'h55667788, 1'b0);
        result("lhu", 32'h00008811, 32'hA4, 32'hF4, 1'b0, 1'b0);

        // LB sign extension, SB lane placement.
        issue(1'b1, 1'b0, 32'h001, 32'h0, LS_B, LS_W, 32'hA5, 32'hF5);
        beat("lb", 32'h000, 4'b0000, 32'h0, 1'b0, 0, 32'h00008000, 1'b0);
        result("lb", 32'hFFFFFF80, 32'hA5, 32'hF5, 1'b0, 1'b0);
        issue(1'b0, 1'b1, 32'h003, 32'h123456A5, LS_W, LS_B, 32'hA6, 32'hF6);
        beat("sb", 32'h000, 4'b1000, 32'hA5000000, 1'b1, 0, 32'h0, 1'b0);
        result("sb", 32'h0, 32'hA6, 32'hF6, 1'b0, 1'b0);

        // Address wrap on beat 1.
        issue(1'b0, 1'b1, 32'hFFFFFFFE, 32'h12345678, LS_W, LS_W, 32'hA7, 32'hF7);
        beat("wrap.b0", 32'hFFFFFFFC, 4'b1100, 32'h56780000, 1'b1, 0, 32'h0, 1'b0);
        beat("wrap.b1", 32'h00000000, 4'b0011, 32'h00001234, 1'b1, 0, 32'h0, 1'b0);
        result("wrap", 32'h0, 32'hA7, 32'hF7, 1'b0, 1'b0);

        // Non-memory op completes the cycle after accept.
        issue(1'b0, 1'b0, 32'h0, 32'h0, LS_W, LS_W, 32'h0000BEEF, 32'h3F800000);
        chk("alu.req", 32'(dmem_req), 32'd0);
        result("alu", 32'h0, 32'h0000BEEF, 32'h3F800000, 1'b0, 1'b0);

        // Error on beat 0 of a split load skips beat 1.
        issue(1'b1, 1'b0, 32'h106, 32'h0, LS_W, LS_W, 32'hA8, 32'hF8);
        beat("err.b0", 32'h104, 4'b0000, 32'h0, 1'b0, 0, 32'h12345678, 1'b1);
        chk("err.req", 32'(dmem_req), 32'd0);
        result("err", 32'h0, 32'hA8, 32'hF8, 1'b0, 1'b1);

        // No-split instance: crossing LW raises misalign_exc, no request.
        mem_read = 1'b1; mem_write = 1'b0; mem_address = 32'h101; load_width = LS_W;
        alu_result = 32'h44; fp_alu_result = 32'h55; in_valid_b = 1'b1;
        #1;
        chk("nosplit.in_ready", 32'(in_ready_b), 32'd1);
        @(negedge clk);
        in_valid_b = 1'b0;
        chk("nosplit.out_valid", 32'(out_valid_b), 32'd1);
        chk("nosplit.misalign", 32'(misalign_b), 32'd1);
        chk("nosplit.load", load_b, 32'h0);
        chk("nosplit.req", 32'(req_b), 32'd0);
        chk("nosplit.alu", alu_b, 32'h44);
        $display("TXN nosplit_lw mis=%0b out_valid=%0b", misalign_b, out_valid_b);
        @(negedge clk);
        chk("nosplit.req_after", 32'(req_b), 32'd0);

        // Grant stall of 5 cycles, then 3 cycles of downstream back-pressure.
        issue(1'b1, 1'b0, 32'h300, 32'h0, LS_W, LS_W, 32'hA9, 32'hF9);
        beat("stall", 32'h300, 4'b0000, 32'h0, 1'b0, 5, 32'hCAFEF00D, 1'b0);
        out_ready = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; alu_result = 32'h999; in_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("hold.out_valid", 32'(out_valid), 32'd1);
            chk("hold.load", mem_load_data, 32'hCAFEF00D);
            chk("hold.alu", mem_alu_result, 32'hA9);
            chk("hold.in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        $display("TXN hold load=0x%08h", mem_load_data);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        chk("hold.release_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("hold.drop", 32'(out_valid), 32'd0);

        // Reset while waiting in RSP0; late rvalid must be ignored.
        issue(1'b1, 1'b0, 32'h400, 32'h0, LS_W, LS_W, 32'hAA, 32'hFA);
        chk("rstmid.req", 32'(dmem_req), 32'd1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid.out_valid", 32'(out_valid), 32'd0);
        chk("rstmid.req", 32'(dmem_req), 32'd0);
        chk("rstmid.addr", dmem_addr, 32'h0);
        chk("rstmid.alu", mem_alu_result, 32'h0);
        chk("rstmid.in_ready", 32'(in_ready), 32'd1);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h77;
        @(negedge clk);
        dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
        chk("rstmid.late_rvalid", 32'(out_valid), 32'd0);
        chk("rstmid.load", mem_load_data, 32'h0);
        $display("TXN reset_mid_txn out_valid=%0b", out_valid);
        issue(1'b1, 1'b0, 32'h500, 32'h0, LS_W, LS_W, 32'hAB, 32'hFB);
        beat("post", 32'h500, 4'b0000, 32'h0, 1'b0, 0, 32'h13579BDF, 1'b0);
        result("post", 32'h13579BDF, 32'hAB, 32'hFB, 1'b0, 1'b0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
